// File: rtl/heap_pq_engine_pkg.sv
// Shared opcodes, FSM states and ordering helper for the heap priority queue.
package heap_pq_engine_pkg;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SIFT_UP,
        ST_SIFT_DOWN
    } heapState_t;

    // Strict ordering: equal keys are never "better", so they never swap.
    function automatic logic isBetter(
        input logic maxHeap,
        input logic aLtB,
        input logic aGtB
    );
        return maxHeap ? aGtB : aLtB;
    endfunction

endpackage

// File: rtl/heap_child_select.sv
// Sift-down decision for one heap level: picks the better child and
// reports whether it should swap with the parent.
module heap_child_select
    import heap_pq_engine_pkg::*;
#(
    parameter int KEY_W    = 32,
    parameter int IDX_W    = 16,
    parameter int MAX_HEAP = 0
) (
    input  logic [IDX_W-1:0] idx,
    input  logic [IDX_W-1:0] count,
    input  logic [KEY_W-1:0] parentKey,
    input  logic [KEY_W-1:0] leftKey,
    input  logic [KEY_W-1:0] rightKey,
    output logic             doSwap,
    output logic [IDX_W-1:0] swapIdx
);

    localparam logic MAX = (MAX_HEAP != 0);

    logic [IDX_W-1:0] leftIdx;
    logic [IDX_W-1:0] rightIdx;
    logic [KEY_W-1:0] bestKey;
    logic             rightWins;

    assign leftIdx  = idx << 1;
    assign rightIdx = leftIdx | IDX_W'(1);

    // Ties go to the left child.
    assign rightWins = (rightIdx <= count) &&
        isBetter(MAX, rightKey < leftKey, rightKey > leftKey);

    assign bestKey = rightWins ? rightKey : leftKey;
    assign swapIdx = rightWins ? rightIdx : leftIdx;

    assign doSwap = (leftIdx <= count) &&
        isBetter(MAX, bestKey < parentKey, bestKey > parentKey);

endmodule

// File: rtl/heap_pq_engine.sv
// Sequential binary-heap priority queue; sift moves one level per clock.
module heap_pq_engine
    import heap_pq_engine_pkg::*;
#(
    parameter int KEY_W    = 32,
    parameter int VAL_W    = 33,
    parameter int DEPTH    = 1000,
    parameter int IDX_W    = 16,
    parameter int MAX_HEAP = 0
) (
    input  logic             system1000,
    input  logic             system1000_rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_op,
    input  logic [KEY_W-1:0] cmd_key,
    input  logic [VAL_W-1:0] cmd_val,
    output logic             rsp_valid,
    output logic             rsp_err,
    output logic [KEY_W-1:0] rsp_key,
    output logic [VAL_W-1:0] rsp_val,
    output logic [IDX_W-1:0] count,
    output logic             empty,
    output logic             full
);

    localparam logic             MAX     = (MAX_HEAP != 0);
    localparam logic [IDX_W-1:0] ONE     = IDX_W'(1);
    localparam logic [IDX_W-1:0] DEPTH_I = IDX_W'(DEPTH);

    logic [KEY_W-1:0] heapKey [1:DEPTH];
    logic [VAL_W-1:0] heapVal [1:DEPTH];

    heapState_t       state, stateNext;
    logic [IDX_W-1:0] idx, idxNext, countNext;
    logic [IDX_W-1:0] parentIdx, childIdx;
    logic [KEY_W-1:0] idxKey, parentKey;
    logic             accept, pushOk, popOk;
    logic             upSwap, downSwap, childSwap;

    // Out-of-range reads return zero; callers bound them by count anyway.
    function automatic logic [KEY_W-1:0] keyAt(input logic [IDX_W-1:0] i);
        return (i >= ONE && i <= DEPTH_I) ? heapKey[i] : '0;
    endfunction

    assign cmd_ready = (state == ST_IDLE);
    assign accept    = cmd_valid & cmd_ready;
    assign pushOk    = accept & (cmd_op == OP_PUSH) & ~full;
    assign popOk     = accept & (cmd_op == OP_POP) & ~empty;

    assign parentIdx = idx >> 1;
    assign idxKey    = keyAt(idx);
    assign parentKey = keyAt(parentIdx);

    assign upSwap = (state == ST_SIFT_UP) && (idx > ONE) &&
        isBetter(MAX, idxKey < parentKey, idxKey > parentKey);

    heap_child_select #(
        .KEY_W   (KEY_W),
        .IDX_W   (IDX_W),
        .MAX_HEAP(MAX_HEAP)
    ) uChildSelect (
        .idx      (idx),
        .count    (count),
        .parentKey(idxKey),
        .leftKey  (keyAt(idx << 1)),
        .rightKey (keyAt((idx << 1) | ONE)),
        .doSwap   (childSwap),
        .swapIdx  (childIdx)
    );

    assign downSwap = (state == ST_SIFT_DOWN) && childSwap;

    always_comb begin
        stateNext = state;
        idxNext   = idx;
        countNext = count;
        unique case (state)
            ST_IDLE: begin
                if (pushOk) begin
                    countNext = count + ONE;
                    idxNext   = count + ONE;
                    stateNext = (count != '0) ? ST_SIFT_UP : ST_IDLE;
                end else if (popOk) begin
                    countNext = count - ONE;
                    idxNext   = ONE;
                    stateNext = (count > IDX_W'(2)) ? ST_SIFT_DOWN : ST_IDLE;
                end
            end
            ST_SIFT_UP: begin
                if (upSwap) idxNext = parentIdx;
                else        stateNext = ST_IDLE;
            end
            ST_SIFT_DOWN: begin
                if (downSwap) idxNext = childIdx;
                else          stateNext = ST_IDLE;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge system1000) begin
        if (system1000_rst) state <= ST_IDLE;
        else                state <= stateNext;
    end

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            idx       <= '0;
            count     <= '0;
            empty     <= 1'b1;
            full      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_key   <= '0;
            rsp_val   <= '0;
        end else begin
            idx       <= idxNext;
            count     <= countNext;
            empty     <= (countNext == '0);
            full      <= (countNext == DEPTH_I);
            rsp_valid <= accept;
            rsp_err   <= accept & ~pushOk & ~popOk;
            rsp_key   <= popOk ? heapKey[1] : '0;
            rsp_val   <= popOk ? heapVal[1] : '0;
        end
    end

    always_ff @(posedge system1000) begin
        if (!system1000_rst) begin
            if (pushOk) begin
                heapKey[count + ONE] <= cmd_key;
                heapVal[count + ONE] <= cmd_val;
            end else if (popOk) begin
                heapKey[1] <= heapKey[count];
                heapVal[1] <= heapVal[count];
            end else if (upSwap) begin
                heapKey[idx]       <= heapKey[parentIdx];
                heapVal[idx]       <= heapVal[parentIdx];
                heapKey[parentIdx] <= heapKey[idx];
                heapVal[parentIdx] <= heapVal[idx];
            end else if (downSwap) begin
                heapKey[idx]      <= heapKey[childIdx];
                heapVal[idx]      <= heapVal[childIdx];
                heapKey[childIdx] <= heapKey[idx];
                heapVal[childIdx] <= heapVal[idx];
            end
        end
    end

endmodule

// File: tb/tb_heap_pq_engine.sv
// Directed and model-checked bench for heap_pq_engine (min, max, small-depth instances).
module tb_heap_pq_engine;

    localparam int KW = 32;
    localparam int VW = 33;
    localparam int IW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          op;
    logic [KW-1:0] key;
    logic [VW-1:0] val;

    logic [2:0]         cv, rdy, rv, re, emp, ful;
    logic [2:0][KW-1:0] rk;
    logic [2:0][VW-1:0] rvl;
    logic [2:0][IW-1:0] cnt;

    int nChecks = 0;
    int nFail   = 0;

    logic          gV, gE;
    logic [KW-1:0] gK;
    logic [VW-1:0] gVal;

    localparam logic [VW-1:0] VA = 33'h1_0000_000A;
    localparam logic [VW-1:0] VB = 33'h0_0000_000B;
    localparam logic [VW-1:0] VC = 33'h1_2345_000C;
    localparam logic [VW-1:0] VD = 33'h0_ABCD_000D;

    heap_pq_engine #(.DEPTH(16), .MAX_HEAP(0)) uMin (
        .system1000(clk), .system1000_rst(rst),
        .cmd_valid(cv[0]), .cmd_ready(rdy[0]), .cmd_op(op),
        .cmd_key(key), .cmd_val(val),
        .rsp_valid(rv[0]), .rsp_err(re[0]),
        .rsp_key(rk[0]), .rsp_val(rvl[0]),
        .count(cnt[0]), .empty(emp[0]), .full(ful[0])
    );

    heap_pq_engine #(.DEPTH(16), .MAX_HEAP(1)) uMax (
        .system1000(clk), .system1000_rst(rst),
        .cmd_valid(cv[1]), .cmd_ready(rdy[1]), .cmd_op(op),
        .cmd_key(key), .cmd_val(val),
        .rsp_valid(rv[1]), .rsp_err(re[1]),
        .rsp_key(rk[1]), .rsp_val(rvl[1]),
        .count(cnt[1]), .empty(emp[1]), .full(ful[1])
    );

    heap_pq_engine #(.DEPTH(4), .MAX_HEAP(0)) uSmall (
        .system1000(clk), .system1000_rst(rst),
        .cmd_valid(cv[2]), .cmd_ready(rdy[2]), .cmd_op(op),
        .cmd_key(key), .cmd_val(val),
        .rsp_valid(rv[2]), .rsp_err(re[2]),
        .rsp_key(rk[2]), .rsp_val(rvl[2]),
        .count(cnt[2]), .empty(emp[2]), .full(ful[2])
    );

    // Waits (bounded) for cmd_ready, issues one command, captures the response.
    task automatic issue(input int u, input logic o,
                         input logic [KW-1:0] k, input logic [VW-1:0] v);
        bit got = 1'b0;
        for (int w = 0; w < 6; w++) begin
            @(negedge clk);
            if (rdy[u]) begin
                got = 1'b1;
                break;
            end
        end
        nChecks++;
        if (!got) begin
            nFail++;
            $display("FAIL stall_u%0d: cmd_ready=%0b after 6 cycles, required 1", u, rdy[u]);
        end
        op = o; key = k; val = v; cv[u] = 1'b1;
        @(posedge clk);
        #1;
        cv[u] = 1'b0;
        gV = rv[u]; gE = re[u]; gK = rk[u]; gVal = rvl[u];
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        nChecks++;
        if (cnt[0] !== 16'd0) begin nFail++; $display("FAIL reset_count: got %0d, required 0", cnt[0]); end
        nChecks++;
        if (emp[0] !== 1'b1) begin nFail++; $display("FAIL reset_empty: got %0b, required 1", emp[0]); end
        nChecks++;
        if (ful[0] !== 1'b0) begin nFail++; $display("FAIL reset_full: got %0b, required 0", ful[0]); end
        nChecks++;
        if (rdy[0] !== 1'b1) begin nFail++; $display("FAIL reset_ready: got %0b, required 1", rdy[0]); end
        nChecks++;
        if (rv[0] !== 1'b0) begin nFail++; $display("FAIL reset_rsp_valid: got %0b, required 0", rv[0]); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_pop_empty();
        issue(0, 1'b1, 32'd0, '0);
        nChecks++;
        if (gV !== 1'b1 || gE !== 1'b1) begin
            nFail++; $display("FAIL pop_empty_rsp: valid=%0b err=%0b, required 1 1", gV, gE);
        end
        nChecks++;
        if (gK !== 32'd0 || gVal !== 33'd0) begin
            nFail++; $display("FAIL pop_empty_data: key=%0h val=%0h, required 0 0", gK, gVal);
        end
        nChecks++;
        if (cnt[0] !== 16'd0 || emp[0] !== 1'b1) begin
            nFail++; $display("FAIL pop_empty_flags: count=%0d empty=%0b, required 0 1", cnt[0], emp[0]);
        end
    endtask

    task automatic pushFour(input int u);
        logic [KW-1:0] keys [4];
        logic [VW-1:0] vals [4];
        keys = '{32'd5, 32'd3, 32'd8, 32'd1};
        vals = '{VA, VB, VC, VD};
        for (int i = 0; i < 4; i++) begin
            issue(u, 1'b0, keys[i], vals[i]);
            nChecks++;
            if (gV !== 1'b1 || gE !== 1'b0 || gK !== 32'd0) begin
                nFail++;
                $display("FAIL push_rsp_u%0d_%0d: valid=%0b err=%0b key=%0h, required 1 0 0", u, i, gV, gE, gK);
            end
        end
    endtask

    task automatic popExpect(input int u, input string tag,
                             input logic [KW-1:0] ek, input logic [VW-1:0] ev);
        issue(u, 1'b1, 32'd0, '0);
        nChecks++;
        if (gV !== 1'b1 || gE !== 1'b0 || gK !== ek || gVal !== ev) begin
            nFail++;
            $display("FAIL %s: valid=%0b err=%0b key=%0d val=%0h, required 1 0 %0d %0h",
                     tag, gV, gE, gK, gVal, ek, ev);
        end
    endtask

    task automatic test_min_order();
        pushFour(0);
        nChecks++;
        if (cnt[0] !== 16'd4) begin nFail++; $display("FAIL min_count: got %0d, required 4", cnt[0]); end
        popExpect(0, "min_pop0", 32'd1, VD);
        popExpect(0, "min_pop1", 32'd3, VB);
        popExpect(0, "min_pop2", 32'd5, VA);
        popExpect(0, "min_pop3", 32'd8, VC);
        nChecks++;
        if (emp[0] !== 1'b1) begin nFail++; $display("FAIL min_empty: got %0b, required 1", emp[0]); end
    endtask

    task automatic test_max_order();
        pushFour(1);
        popExpect(1, "max_pop0", 32'd8, VC);
        popExpect(1, "max_pop1", 32'd5, VA);
        popExpect(1, "max_pop2", 32'd3, VB);
        popExpect(1, "max_pop3", 32'd1, VD);
        nChecks++;
        if (emp[1] !== 1'b1) begin nFail++; $display("FAIL max_empty: got %0b, required 1", emp[1]); end
    endtask

    task automatic test_full();
        pushFour(2);
        nChecks++;
        if (ful[2] !== 1'b1 || cnt[2] !== 16'd4) begin
            nFail++; $display("FAIL full_flag: full=%0b count=%0d, required 1 4", ful[2], cnt[2]);
        end
        issue(2, 1'b0, 32'd0, 33'h1FF);
        nChecks++;
        if (gV !== 1'b1 || gE !== 1'b1 || gK !== 32'd0) begin
            nFail++; $display("FAIL full_push_err: valid=%0b err=%0b key=%0h, required 1 1 0", gV, gE, gK);
        end
        nChecks++;
        if (cnt[2] !== 16'd4 || ful[2] !== 1'b1) begin
            nFail++; $display("FAIL full_hold: count=%0d full=%0b, required 4 1", cnt[2], ful[2]);
        end
        popExpect(2, "full_pop0", 32'd1, VD);
        nChecks++;
        if (ful[2] !== 1'b0) begin nFail++; $display("FAIL full_clear: got %0b, required 0", ful[2]); end
        popExpect(2, "full_pop1", 32'd3, VB);
        popExpect(2, "full_pop2", 32'd5, VA);
        popExpect(2, "full_pop3", 32'd8, VC);
    endtask

    task automatic test_ties();
        issue(0, 1'b0, 32'd7, 33'h0_0000_0111);
        issue(0, 1'b0, 32'd7, 33'h1_0000_0222);
        popExpect(0, "tie_pop0", 32'd7, 33'h0_0000_0111);
        popExpect(0, "tie_pop1", 32'd7, 33'h1_0000_0222);
    endtask

    task automatic test_sift_timing();
        int low = 0;
        for (int i = 1; i <= 6; i++) issue(0, 1'b0, 32'(i * 10), '0);
        issue(0, 1'b0, 32'd1, '0);
        for (int c = 0; c < 8; c++) begin
            if (rdy[0]) break;
            low++;
            @(posedge clk);
            #1;
        end
        nChecks++;
        if (low != 3) begin nFail++; $display("FAIL sift_up_cycles: got %0d, required 3", low); end
        issue(0, 1'b0, 32'd0, '0);
        nChecks++;
        if (rdy[0] !== 1'b0 || cnt[0] !== 16'd8) begin
            nFail++; $display("FAIL mid_sift: ready=%0b count=%0d, required 0 8", rdy[0], cnt[0]);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        nChecks++;
        if (cnt[0] !== 16'd0 || rdy[0] !== 1'b1 || emp[0] !== 1'b1) begin
            nFail++;
            $display("FAIL sift_reset: count=%0d ready=%0b empty=%0b, required 0 1 1", cnt[0], rdy[0], emp[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        issue(0, 1'b1, 32'd0, '0);
        nChecks++;
        if (gE !== 1'b1) begin nFail++; $display("FAIL sift_reset_pop: err=%0b, required 1", gE); end
    endtask

    task automatic test_random();
        logic [KW-1:0] q[$];
        logic [KW-1:0] k;
        logic          o;
        logic          expErr;
        int            m;
        pulseReset();
        for (int n = 0; n < 1500; n++) begin
            o = ($urandom_range(0, 99) < ((n < 750) ? 40 : 60)) ? 1'b1 : 1'b0;
            k = 32'($urandom_range(0, 40));
            issue(0, o, k, 33'(n));
            if (o == 1'b0) begin
                expErr = (q.size() == 16);
                if (!expErr) q.push_back(k);
            end else begin
                expErr = (q.size() == 0);
                if (!expErr) begin
                    m = 0;
                    foreach (q[i]) if (q[i] < q[m]) m = i;
                    nChecks++;
                    if (gK !== q[m]) begin
                        nFail++; $display("FAIL rnd_pop_%0d: key=%0d, required %0d", n, gK, q[m]);
                    end
                    q.delete(m);
                end
            end
            nChecks++;
            if (gE !== expErr || cnt[0] !== IW'(q.size())) begin
                nFail++;
                $display("FAIL rnd_state_%0d: err=%0b count=%0d, required %0b %0d", n, gE, cnt[0], expErr, q.size());
            end
        end
    endtask

    initial begin
        cv = '0; op = 1'b0; key = '0; val = '0;
        test_reset();
        test_pop_empty();
        test_min_order();
        test_max_order();
        test_full();
        test_ties();
        test_sift_timing();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
